mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
// Memory-side responder for the SLC-3 datapath: services the CPU's MAR/MDR read and write requests (MIO_EN path).
// Holds a small on-chip word memory plus one memory-mapped I/O word (switches in, hex display register out).
// Inserts programmable wait states and returns ready R to the microsequencer, which holds its state until R=1.
// PARAMETERS
// DEPTH        256      number of 16-bit words of on-chip memory (addresses 0..DEPTH-1), power of 2, <= 32768
// WAIT_STATES  2        extra BUSY cycles per access (0..15)
// IO_ADDR      16'hFFFF memory-mapped I/O address (read = SW, write = HEX_OUT)
// PORTS
// Clk            in   1   system clock, all state on rising edge
// Reset          in   1   asynchronous, active-high reset
// MEM_EN         in   1   access request from CPU (MIO_EN)
// MEM_WE         in   1   1 = write, 0 = read; sampled with request
// ADDR           in   16  word address (MAR)
// DATA_TO_MEM    in   16  write data (MDR)
// SW             in   16  switch inputs, read at IO_ADDR
// DATA_FROM_MEM  out  16  read data to MDR input mux (MDR_In)
// R              out  1   ready: access completes this cycle
// HEX_OUT        out  16  hex display register, written at IO_ADDR
// BEHAVIOUR
// Reset (async, immediate): state=IDLE, R=0, DATA_FROM_MEM=0, HEX_OUT=0, wait counter=0; memory array not cleared.
// FSM states IDLE, BUSY, DONE; R = (state==DONE), decoded from registered state only.
// IDLE: MEM_EN=1 at edge -> capture ADDR, MEM_WE, DATA_TO_MEM; go BUSY (cnt=WAIT_STATES-1) or DONE if WAIT_STATES=0.
// BUSY: cnt decrements each edge; at cnt==0 go DONE. MEM_EN/ADDR/data changes while BUSY are ignored.
// DONE: R=1 for exactly one cycle; next state IDLE unconditionally.
// Latency: R high in cycle WAIT_STATES+1 after the accepting edge; access time WAIT_STATES+2 cycles incl. accept.
// Back-to-back: MEM_EN still high in the cycle after DONE (IDLE) is accepted as a new access.
// Read: data loaded into DATA_FROM_MEM on the edge entering DONE; held stable until next read completes.
// Read source: addr<DEPTH -> mem[addr]; addr==IO_ADDR -> SW sampled on that edge; else 16'h0000.
// Write: committed on the edge entering DONE; addr<DEPTH -> mem[addr]; addr==IO_ADDR -> HEX_OUT; else dropped.
// Writes never change DATA_FROM_MEM.
// Address decode uses full 16 bits; no aliasing of out-of-range addresses onto memory.
// Reset asserted mid-access: access aborted, no write committed, R stays 0, HEX_OUT returns to 0.
// MEM_EN deasserted while BUSY: access still completes and R still pulses (CPU must not abort).
// TESTING
// Reset with WAIT_STATES=2: R=0, DATA_FROM_MEM=0, HEX_OUT=0; release, MEM_EN=0 for 10 cycles -> R never asserts.
// Write 16'hBEEF to 16'h0010 then read 16'h0010 -> R exactly 3 cycles after each accept, DATA_FROM_MEM=16'hBEEF.
// Write 16'h1234 to 16'hFFFF -> HEX_OUT=16'h1234 at DONE edge; SW=16'h00A5, read 16'hFFFF -> 16'h00A5.
// Read 16'h8000 (out of range, DEPTH=256) -> 16'h0000; write there leaves mem[16'h0000] unchanged.
// WAIT_STATES=0, MEM_EN held high across two reads -> R pulses 1 cycle each, one IDLE cycle between pulses.
// Reset pulse during BUSY of write 16'h5555 to 16'h0020 -> R stays 0, later read of 16'h0020 returns prior value.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the SLC-3 datapath.
// Services MAR/MDR read/write requests against a small on-chip word memory
// plus one memory-mapped I/O word (switches in, hex display register out).
// Each access takes WAIT_STATES busy cycles, then a single-cycle ready pulse R.
module mem_responder #(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MEM_EN,
    input  logic        MEM_WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] DATA_TO_MEM,
    input  logic [15:0] SW,
    output logic [15:0] DATA_FROM_MEM,
    output logic        R,
    output logic [15:0] HEX_OUT
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [16:0] DEPTH_L  = 17'(DEPTH);
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic        NO_WAIT  = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] hex_q, hex_d;

    // Request captured at the accepting edge; held unchanged while busy.
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        we_q;

    logic [15:0] mem [DEPTH];

    logic        commit;
    logic        acc_we;
    logic [15:0] acc_addr;
    logic [15:0] acc_wdata;
    logic        in_range;
    logic        is_io;
    logic [AW-1:0] mem_idx;
    logic        mem_wr;

    // Select the request being completed: with zero wait states the access
    // commits on the accepting edge itself, so the live inputs are used.
    always_comb begin
        if (state_q == IDLE) begin
            acc_addr  = ADDR;
            acc_we    = MEM_WE;
            acc_wdata = DATA_TO_MEM;
        end else begin
            acc_addr  = addr_q;
            acc_we    = we_q;
            acc_wdata = wdata_q;
        end
        // Full 16-bit decode: out-of-range addresses never alias onto memory.
        in_range = ({1'b0, acc_addr} < DEPTH_L);
        is_io    = (acc_addr == IO_ADDR);
        mem_idx  = acc_addr[AW-1:0];
    end

    // Next-state, wait counter and read/hex data for the completing access.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        hex_d   = hex_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (MEM_EN) begin
                    if (NO_WAIT) begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (commit) begin
            if (acc_we) begin
                if (!in_range && is_io) begin
                    hex_d = acc_wdata;
                end
            end else begin
                if (in_range) begin
                    rdata_d = mem[mem_idx];
                end else if (is_io) begin
                    rdata_d = SW;
                end else begin
                    rdata_d = 16'h0000;
                end
            end
        end
    end

    // Control state and architecturally visible output registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 16'h0000;
            hex_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            hex_q   <= hex_d;
        end
    end

    // Latch the request when an access is accepted.
    always_ff @(posedge Clk) begin
        if (state_q == IDLE && MEM_EN) begin
            addr_q  <= ADDR;
            we_q    <= MEM_WE;
            wdata_q <= DATA_TO_MEM;
        end
    end

    // A reset coinciding with the completing edge aborts the write.
    assign mem_wr = commit && acc_we && in_range && !Reset;

    // Word memory; deliberately not cleared by reset.
    always_ff @(posedge Clk) begin
        if (mem_wr) begin
            mem[mem_idx] <= acc_wdata;
        end
    end

    assign R             = (state_q == DONE);
    assign DATA_FROM_MEM = rdata_q;
    assign HEX_OUT       = hex_q;

endmodule
